mema_ctrl: RTL

Controller and two-port arbiter for the 8x8 single-port memory (memoryA). It sequences every memory access: it arbitrates round-robin between two requesters, drives the memory's address, write-enable and write-data pins with clean single-cycle commands, and returns read data with a per-requester valid pulse. It also provides a sequenced clear that zeroes all eight locations by ordinary writes, so no memory-side reset clear is needed.

---
 rtl/mema_ctrl_if.sv | 37 +++
 rtl/mema_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/mema_ctrl_if.sv
// Requester, clear and memory-pin bundle for the memoryA controller.
// slave is the controller side; master is the requester/memory side.
interface mema_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_start, mem_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, clr_busy, clr_done, mem_addr, mem_we, mem_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_start, mem_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, clr_busy, clr_done, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/mema_ctrl.sv
// Two-port round-robin controller for the 8x8 single-port memoryA, with a
// sequenced clear that zeroes every location through ordinary writes.
module mema_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 8
) (
  input logic       clock,
  input logic       reset,
  mema_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  state_t state;
  logic   lastGnt;  // 1 = requester 1 was granted last; also the owner of the access in flight
  logic   winner1;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  always_comb begin
    winner1 = bus.req1 & (~bus.req0 | ~lastGnt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      lastGnt      <= 1'b1;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.rvalid0  <= 1'b0;
      bus.rvalid1  <= 1'b0;
      bus.rdata    <= DATA_W'(0);
      bus.clr_busy <= 1'b0;
      bus.clr_done <= 1'b0;
      bus.mem_addr <= ADDR_W'(0);
      bus.mem_we   <= 1'b0;
      bus.mem_din  <= DATA_W'(0);
    end else begin
      bus.rvalid0  <= 1'b0;
      bus.rvalid1  <= 1'b0;
      bus.clr_done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.clr_start) begin
            state        <= CLEAR;
            bus.clr_busy <= 1'b1;
            bus.mem_we   <= 1'b1;
            bus.mem_din  <= DATA_W'(0);
            bus.mem_addr <= ADDR_W'(0);
          end else if (bus.req0 | bus.req1) begin
            state        <= ISSUE;
            lastGnt      <= winner1;
            bus.gnt0     <= ~winner1;
            bus.gnt1     <= winner1;
            bus.mem_we   <= winner1 ? bus.we1    : bus.we0;
            bus.mem_addr <= winner1 ? bus.addr1  : bus.addr0;
            bus.mem_din  <= winner1 ? bus.wdata1 : bus.wdata0;
          end
        end

        // mem_we still carries the kind of the command being issued.
        ISSUE: begin
          bus.gnt0    <= 1'b0;
          bus.gnt1    <= 1'b0;
          bus.mem_we  <= 1'b0;
          bus.mem_din <= DATA_W'(0);
          state       <= bus.mem_we ? IDLE : RDWAIT;
        end

        RDWAIT: begin
          bus.rdata   <= bus.mem_dout;
          bus.rvalid0 <= ~lastGnt;
          bus.rvalid1 <= lastGnt;
          state       <= IDLE;
        end

        CLEAR: begin
          if (bus.mem_addr == LAST_ADDR) begin
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= ADDR_W'(0);
            bus.clr_busy <= 1'b0;
            bus.clr_done <= 1'b1;
            state        <= IDLE;
          end else begin
            bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
